regfile_mp_sb: RTL and testbench

- Parametrised multi-port integer register file for the next core generation (dual-issue / multicycle units).
- NRD combinational read ports and two write ports with fixed priority; optional same-cycle write-to-read bypass; configurable hardwired zero register.
- Integrated per-register pending-write scoreboard: issue logic marks destinations busy; writeback clears them. The block sits between decode/issue and the execute/writeback stages.

---
 rtl/regfile_mp_sb.sv | 136 +++++++++++++
 tb/tb_regfile_mp_sb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with a per-register pending-write scoreboard.
// NRD combinational read ports, two prioritised write ports (B over A), optional bypass.

module regfile_mp_sb_rport #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic            rst,
  input  logic [AW-1:0]   ra,
  input  logic [XLEN-1:0] stored,
  input  logic            pend,
  input  logic            wea,
  input  logic [AW-1:0]   waa,
  input  logic [XLEN-1:0] wda,
  input  logic            clra,
  input  logic            web,
  input  logic [AW-1:0]   wab,
  input  logic [XLEN-1:0] wdb,
  input  logic            clrb,
  output logic [XLEN-1:0] rd,
  output logic            rbusy
);
  logic is_zero, hit_a, hit_b;

  assign is_zero = (ZERO_REG != 0) && (ra == '0);
  assign hit_a   = wea && (waa == ra);
  assign hit_b   = web && (wab == ra);

  always_comb begin
    rd    = stored;
    rbusy = pend;
    if (BYPASS != 0) begin
      if (hit_b)      rd = wdb;
      else if (hit_a) rd = wda;
      // a clearing writeback this cycle lets the consumer issue off the bypass
      if ((hit_a && clra) || (hit_b && clrb)) rbusy = 1'b0;
    end
    if (rst || is_zero) begin
      rd    = '0;
      rbusy = 1'b0;
    end
  end
endmodule

module regfile_mp_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic                wea,
  input  logic [AW-1:0]       waa,
  input  logic [XLEN-1:0]     wda,
  input  logic                clra,
  input  logic                web,
  input  logic [AW-1:0]       wab,
  input  logic [XLEN-1:0]     wdb,
  input  logic                clrb,
  input  logic                iss,
  input  logic [AW-1:0]       isrd,
  input  logic                flush,
  output logic                any_busy
);
  logic [NREGS-1:0][XLEN-1:0] mem;
  logic [NREGS-1:0]           pending, pend_nxt;
  logic                       wr_a, wr_b, set_ok;

  assign wr_a   = wea && !((ZERO_REG != 0) && (waa == '0));
  assign wr_b   = web && !((ZERO_REG != 0) && (wab == '0));
  assign set_ok = iss && !((ZERO_REG != 0) && (isrd == '0));

  // port B is written last so it wins an address collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else begin
      if (wr_a) mem[waa] <= wda;
      if (wr_b) mem[wab] <= wdb;
    end
  end

  // clears first, then the set, so a new producer keeps ownership
  always_comb begin
    pend_nxt = pending;
    if (flush) begin
      pend_nxt = '0;
    end else begin
      if (wea && clra) pend_nxt[waa] = 1'b0;
      if (web && clrb) pend_nxt[wab] = 1'b0;
      if (set_ok)      pend_nxt[isrd] = 1'b1;
    end
    if (ZERO_REG != 0) pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      any_busy <= 1'b0;
    end else begin
      pending  <= pend_nxt;
      any_busy <= |pend_nxt;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] rai;
    assign rai = ra[i*AW +: AW];
    regfile_mp_sb_rport #(
      .XLEN(XLEN), .AW(AW), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rport (
      .rst   (rst),
      .ra    (rai),
      .stored(mem[rai]),
      .pend  (pending[rai]),
      .wea   (wea),
      .waa   (waa),
      .wda   (wda),
      .clra  (clra),
      .web   (web),
      .wab   (wab),
      .wdb   (wdb),
      .clrb  (clrb),
      .rd    (rd[i*XLEN +: XLEN]),
      .rbusy (rbusy[i])
    );
  end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench: directed scenarios plus randomized traffic against an array model,
// driving a bypassing instance and a non-bypassing instance from the same stimulus.

module tb_regfile_mp_sb;
  logic        clk, rst;
  logic [4:0]  rap [2];
  logic [9:0]  ra;
  logic [63:0] rd_b, rd_n;
  logic [1:0]  rbusy_b, rbusy_n;
  logic        any_b, any_n;
  logic        wea, web, clra, clrb, iss, flush;
  logic [4:0]  waa, wab, isrd;
  logic [31:0] wda, wdb;

  int n_cmp, n_err;
  logic [31:0] mreg [32];
  logic        mpend [32];
  logic        many;

  assign ra = {rap[1], rap[0]};

  regfile_mp_sb #(.BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd_b), .rbusy(rbusy_b),
    .wea(wea), .waa(waa), .wda(wda), .clra(clra),
    .web(web), .wab(wab), .wdb(wdb), .clrb(clrb),
    .iss(iss), .isrd(isrd), .flush(flush), .any_busy(any_b));

  regfile_mp_sb #(.BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd_n), .rbusy(rbusy_n),
    .wea(wea), .waa(waa), .wda(wda), .clra(clra),
    .web(web), .wab(wab), .wdb(wdb), .clrb(clrb),
    .iss(iss), .isrd(isrd), .flush(flush), .any_busy(any_n));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp) begin
      if (web && wab == a) return wdb;
      if (wea && waa == a) return wda;
    end
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && ((wea && clra && waa == a) || (web && clrb && wab == a))) return 1'b0;
    return mpend[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mreg[i]  = 32'h0;
      mpend[i] = 1'b0;
    end
    many = 1'b0;
  endtask

  task automatic idle();
    wea = 0; web = 0; clra = 0; clrb = 0; iss = 0; flush = 0;
    waa = 0; wab = 0; isrd = 0; wda = 0; wdb = 0;
  endtask

  // advance one clock; the model applies the architectural rules on the same edge
  task automatic tick();
    logic [31:0] nreg [32];
    logic        npend [32];
    for (int i = 0; i < 32; i++) begin
      nreg[i]  = mreg[i];
      npend[i] = mpend[i];
    end
    if (wea && waa != 0) nreg[waa] = wda;
    if (web && wab != 0) nreg[wab] = wdb;
    if (flush) begin
      for (int i = 0; i < 32; i++) npend[i] = 1'b0;
    end else begin
      if (wea && clra) npend[waa] = 1'b0;
      if (web && clrb) npend[wab] = 1'b0;
      if (iss && isrd != 0) npend[isrd] = 1'b1;
    end
    @(posedge clk);
    many = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mreg[i]  = nreg[i];
      mpend[i] = npend[i];
      many     = many | npend[i];
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle(); rap[0] = 5; rap[1] = 9; model_clear();
    repeat (2) @(posedge clk);
    #2 rst = 0; #1;
    n_cmp++; if (any_b !== 1'b0 || rd_b[31:0] !== 32'h0)
      begin n_err++; $display("FAIL reset_init any=%b rd=%h want 0/0", any_b, rd_b[31:0]); end
    wea = 1; waa = 5; wda = 32'hDEADBEEF; iss = 1; isrd = 9;
    tick(); idle();
    #1;
    n_cmp++; if (rd_n[31:0] !== 32'hDEADBEEF || any_b !== 1'b1 || rbusy_b[1] !== 1'b1)
      begin n_err++; $display("FAIL reset_pre rd=%h any=%b busy=%b want deadbeef/1/1", rd_n[31:0], any_b, rbusy_b[1]); end
    wea = 1; waa = 5; wda = 32'h12345678;
    #2 rst = 1; #1;
    n_cmp++; if (rd_b[31:0] !== 32'h0 || rd_n[31:0] !== 32'h0 || any_b !== 1'b0 || any_n !== 1'b0 || rbusy_b !== 2'b00)
      begin n_err++; $display("FAIL reset_async rd=%h/%h any=%b%b busy=%b want 0", rd_b[31:0], rd_n[31:0], any_b, any_n, rbusy_b); end
    @(posedge clk); #2;
    idle(); rst = 0; model_clear(); #1;
    n_cmp++; if (rd_b[31:0] !== 32'h0 || rd_n[31:0] !== 32'h0 || rbusy_n[1] !== 1'b0)
      begin n_err++; $display("FAIL reset_discard rd=%h/%h busy=%b want 0", rd_b[31:0], rd_n[31:0], rbusy_n[1]); end
  endtask

  task automatic test_collision();
    idle();
    wea = 1; waa = 7; wda = 32'h1111; web = 1; wab = 7; wdb = 32'h2222; rap[0] = 7;
    #1;
    n_cmp++; if (rd_b[31:0] !== 32'h2222)
      begin n_err++; $display("FAIL collision_bypass rd=%h want 00002222", rd_b[31:0]); end
    tick(); idle(); #1;
    n_cmp++; if (rd_b[31:0] !== 32'h2222 || rd_n[31:0] !== 32'h2222)
      begin n_err++; $display("FAIL collision_store rd=%h/%h want 00002222", rd_b[31:0], rd_n[31:0]); end
  endtask

  task automatic test_bypass();
    idle();
    wea = 1; waa = 3; wda = 32'h0BAD0BAD; tick(); idle();
    web = 1; wab = 3; wdb = 32'hA5A5A5A5; wea = 1; waa = 3; wda = 32'h77777777; rap[0] = 3;
    #1;
    n_cmp++; if (rd_b[31:0] !== 32'hA5A5A5A5 || rd_n[31:0] !== 32'h0BAD0BAD)
      begin n_err++; $display("FAIL bypass_same rd=%h/%h want a5a5a5a5/0bad0bad", rd_b[31:0], rd_n[31:0]); end
    web = 0; #1;
    n_cmp++; if (rd_b[31:0] !== 32'h77777777)
      begin n_err++; $display("FAIL bypass_porta rd=%h want 77777777", rd_b[31:0]); end
    web = 1; tick(); idle(); #1;
    n_cmp++; if (rd_b[31:0] !== 32'hA5A5A5A5 || rd_n[31:0] !== 32'hA5A5A5A5)
      begin n_err++; $display("FAIL bypass_next rd=%h/%h want a5a5a5a5", rd_b[31:0], rd_n[31:0]); end
  endtask

  task automatic test_zero();
    idle();
    wea = 1; waa = 0; wda = 32'hFFFFFFFF; web = 1; wab = 0; wdb = 32'hFFFFFFFF;
    iss = 1; isrd = 0; rap[0] = 0; rap[1] = 0;
    #1;
    n_cmp++; if (rd_b !== 64'h0 || rbusy_b !== 2'b00)
      begin n_err++; $display("FAIL zero_same rd=%h busy=%b want 0", rd_b, rbusy_b); end
    tick(); idle(); #1;
    n_cmp++; if (rd_b !== 64'h0 || rd_n !== 64'h0 || rbusy_n !== 2'b00 || any_b !== 1'b0)
      begin n_err++; $display("FAIL zero_after rd=%h/%h busy=%b any=%b want 0", rd_b, rd_n, rbusy_n, any_b); end
  endtask

  task automatic test_sb_issue_clear();
    idle();
    iss = 1; isrd = 9; rap[0] = 9; rap[1] = 2; tick(); idle(); #1;
    n_cmp++; if (rbusy_b[0] !== 1'b1 || rbusy_n[0] !== 1'b1 || rbusy_b[1] !== 1'b0 || any_b !== 1'b1)
      begin n_err++; $display("FAIL sb_set busy=%b/%b any=%b want 01/01/1", rbusy_b, rbusy_n, any_b); end
    wea = 1; clra = 1; waa = 9; wda = 32'h42; #1;
    n_cmp++; if (rbusy_b[0] !== 1'b0 || rd_b[31:0] !== 32'h42 || rbusy_n[0] !== 1'b1)
      begin n_err++; $display("FAIL sb_clear_same busy=%b/%b rd=%h want 0/1/42", rbusy_b[0], rbusy_n[0], rd_b[31:0]); end
    tick(); idle(); #1;
    n_cmp++; if (rbusy_b[0] !== 1'b0 || rbusy_n[0] !== 1'b0 || any_b !== 1'b0 || rd_n[31:0] !== 32'h42)
      begin n_err++; $display("FAIL sb_clear_next busy=%b/%b any=%b rd=%h want 0/0/0/42", rbusy_b[0], rbusy_n[0], any_b, rd_n[31:0]); end
  endtask

  task automatic test_sb_priority();
    idle();
    iss = 1; isrd = 4; web = 1; clrb = 1; wab = 4; wdb = 32'h44; rap[0] = 4; rap[1] = 6;
    tick(); idle(); #1;
    n_cmp++; if (rbusy_b[0] !== 1'b1 || rbusy_n[0] !== 1'b1 || any_b !== 1'b1)
      begin n_err++; $display("FAIL sb_set_wins busy=%b/%b any=%b want 1/1/1", rbusy_b[0], rbusy_n[0], any_b); end
    wea = 1; clra = 1; waa = 12; tick(); idle(); #1;
    n_cmp++; if (rbusy_b[0] !== 1'b1 || any_n !== 1'b1)
      begin n_err++; $display("FAIL sb_clear_idle busy=%b any=%b want 1/1", rbusy_b[0], any_n); end
    flush = 1; iss = 1; isrd = 6; tick(); idle(); #1;
    n_cmp++; if (rbusy_b !== 2'b00 || rbusy_n !== 2'b00 || any_b !== 1'b0 || any_n !== 1'b0)
      begin n_err++; $display("FAIL sb_flush busy=%b/%b any=%b%b want 0", rbusy_b, rbusy_n, any_b, any_n); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wea   = $urandom_range(0, 1);
      web   = $urandom_range(0, 1);
      clra  = $urandom_range(0, 1);
      clrb  = $urandom_range(0, 1);
      iss   = $urandom_range(0, 1);
      flush = ($urandom_range(0, 15) == 0);
      waa   = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wab   = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      isrd  = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wda   = $urandom;
      wdb   = $urandom;
      for (int p = 0; p < 2; p++)
        rap[p] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      #1;
      for (int p = 0; p < 2; p++) begin
        n_cmp++;
        if (rd_b[p*32 +: 32] !== exp_rd(rap[p], 1'b1) || rbusy_b[p] !== exp_busy(rap[p], 1'b1)) begin
          n_err++;
          $display("FAIL rand_byp cyc=%0d port=%0d a=%0d rd=%h busy=%b want %h/%b", c, p, rap[p],
                   rd_b[p*32 +: 32], rbusy_b[p], exp_rd(rap[p], 1'b1), exp_busy(rap[p], 1'b1));
        end
        n_cmp++;
        if (rd_n[p*32 +: 32] !== exp_rd(rap[p], 1'b0) || rbusy_n[p] !== exp_busy(rap[p], 1'b0)) begin
          n_err++;
          $display("FAIL rand_nobyp cyc=%0d port=%0d a=%0d rd=%h busy=%b want %h/%b", c, p, rap[p],
                   rd_n[p*32 +: 32], rbusy_n[p], exp_rd(rap[p], 1'b0), exp_busy(rap[p], 1'b0));
        end
      end
      tick();
      n_cmp++;
      if (any_b !== many || any_n !== many) begin
        n_err++;
        $display("FAIL rand_any cyc=%0d any=%b%b want %b", c, any_b, any_n, many);
      end
    end
    idle();
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    test_reset();
    test_collision();
    test_bypass();
    test_zero();
    test_sb_issue_clear();
    test_sb_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
